reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order retirement buffer for the out-of-order core; the responder end of the dispatcher's allocation, operand-query and rollback interfaces. Allocates one entry per dispatched instruction and hands its ROB id back as the rename tag. Captures results from the RS and LS common data buses and answers the dispatcher's Q1/Q2 readiness queries. Retires entries from the head in program order into the register file and load/store buffer, and raises the global rollback on a mispredicted branch.

## Interface
- ROB_SIZE, 16: number of entries; ids run 1..ROB_SIZE, and id 0 (`ZERO_ROB`) means "no dependency".
- ID_W, 5: ROB id width, matches `ROB_ID_TYPE`.
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  global ready; low freezes all state
- ena_from_dsp  in  1  allocate one entry this cycle
- rd_from_dsp, is_jump_from_dsp, predicted_jump_from_dsp  in  5/1/1  entry fields
- pc_from_dsp, rollback_pc_from_dsp  in  32/32  instruction pc, redirect target on mispredict
- rob_id_to_dsp  out  ID_W  id the next allocation will receive (tail), combinational
- full_to_if  out  1  fetch stall
- Q1_from_dsp, Q2_from_dsp  in  ID_W  query tags
- Q1_ready_to_dsp, Q2_ready_to_dsp  out  1  tagged entry busy and result ready, combinational
- ready_data1_to_dsp, ready_data2_to_dsp  out  32  that entry's result, combinational
- valid_from_rs_cdb, rob_id_from_rs_cdb, result_from_rs_cdb  in  1/ID_W/32
- valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb  in  1/ID_W/32
- commit_ena_to_reg, commit_rd_to_reg, commit_data_to_reg, commit_rob_id_to_reg  out  1/5/32/ID_W  registered retirement write
- commit_ena_to_lsb, commit_rob_id_to_lsb  out  1/ID_W  registered; the LSB may now perform the store with this id
- rollback_flag_to_all  out  1  registered flush pulse
- rollback_pc_to_if  out  32  fetch redirect target, valid while the flag is high

## Operation
- Per-entry state: busy, ready, rd, data, is_jump, predicted_jump, pc, rollback_pc. The buffer is circular: head = oldest entry, tail = next free id, plus a count register.
- **Allocate.** On ena_from_dsp: entry[tail] gets busy=1, ready=0 and the supplied fields. Tail advances; after ROB_SIZE it wraps to 1, never 0.
- **Writeback.** A valid RS or LS CDB beat on a busy entry sets ready=1 and data=result. If both buses target different ids in the same cycle, both entries are written. A CDB beat on a non-busy id is ignored.
- **Jump entries.** For entries with is_jump=1, the RS result bit0 is the actual taken bit. The register commit value for such an entry is pc+4.
- **Query.** Q=0 or a non-busy entry returns ready=0, data=0. The answer reflects registered state only; the dispatcher bypasses same-cycle CDB traffic itself.
- **Commit.** Each cycle, if the head entry is busy and ready:
  - pulse commit_ena_to_reg with rd, data and id; rd=0 is still signalled, and the register file ignores it;
  - pulse commit_ena_to_lsb with the id;
  - clear busy and advance head.
- **Mispredict.** A jump entry whose taken bit differs from predicted_jump commits normally. In the same registered cycle, rollback_flag_to_all goes high and rollback_pc_to_if takes that entry's rollback_pc.
- **Rollback.** In the cycle after the flag is raised: all busy bits clear, head=tail=1, count=0. Allocations and CDB beats in the flag-high cycle are discarded. No commit happens while the flag is high.
- **Full.** full_to_if = (count >= ROB_SIZE-2). This leaves margin for the fetch and dispatch stages in flight.
- **Simultaneous allocate and commit:** count is unchanged. Allocation into an entry freed in the same cycle is legal only after the head has advanced; with the full margin, tail never equals a busy head.

## Timing
- Reset (rst_n low, asynchronous): head=tail=1, count=0, all busy=0, every registered output 0, rollback_pc_to_if=0. Combinational outputs follow: rob_id_to_dsp=1, full_to_if=0, query outputs 0.
- Allocate at edge N → entry queryable from cycle N+1 (ready=0).
- CDB beat at edge N → query ready=1 from cycle N+1.
- Earliest commit is the edge after the entry becomes ready. Commit outputs are valid for exactly one cycle.
- Mispredict at edge N: flag and commit high in cycle N+1, buffer empty in cycle N+2, flag low in N+2.
- rdy=0: no state change. Registered pulse outputs drop to 0; all other outputs hold.
- Peak throughput: one allocation and one commit per cycle.

## Test plan
- **Reset mid-operation:** reset asserted with 5 busy entries → rob_id_to_dsp=1, count=0, all commit and rollback outputs 0, without waiting for a clock edge.
- **Single ALU instruction:** allocate rd=3, then an RS CDB beat with id=1, result=0x2A → Q1_from_dsp=1 reads ready=1, data=0x2A. Next edge: commit_ena_to_reg=1, rd=3, data=0x2A, id=1.
- **Out-of-order completion:** allocate ids 1, 2, 3; CDB for 3, then 2, then 1 → commits occur in order 1, 2, 3 on consecutive cycles.
- **Fill and wrap:** 14 allocations → full_to_if=1. Commit 2, allocate 4 more → ids wrap 15, 16, 1, 2 and id 0 is never issued.
- **Mispredict:** jump entry with predicted_jump=0, RS result bit0=1, rollback_pc=0x100, two younger entries allocated → commit of the jump with data=pc+4, rollback_flag_to_all=1, rollback_pc_to_if=0x100. Next cycle count=0 and rob_id_to_dsp=1; the younger entries never commit.
- **Dual CDB:** RS beat for id 2 and LS beat for id 4 in the same cycle → both queries report ready with their respective data.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer for the out-of-order core.
//
// Allocates one entry per dispatched instruction and returns its id as the
// rename tag. Results arrive on the RS and LS common data buses. Entries retire
// from the head in program order to the register file and the load/store
// buffer. A mispredicted jump commits normally, and then flushes the whole
// buffer.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   rdy                           global ready; low freezes all state
//   ena_from_dsp + entry fields   allocate one entry at the tail
//   rob_id_to_dsp                 id the next allocation receives (comb)
//   full_to_if                    fetch stall (comb)
//   Q1/Q2_from_dsp                readiness query tags
//   Q1/Q2_ready_to_dsp            query result ready (comb)
//   ready_data1/2_to_dsp          query result data (comb)
//   *_rs_cdb, *_ls_cdb            result writeback buses
//   commit_*_to_reg               registered retirement write
//   commit_*_to_lsb               registered store release
//   rollback_flag_to_all          registered flush pulse
//   rollback_pc_to_if             redirect target, valid while the flag is high
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int ID_W     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rdy,
  input  logic            ena_from_dsp,
  input  logic [4:0]      rd_from_dsp,
  input  logic            is_jump_from_dsp,
  input  logic            predicted_jump_from_dsp,
  input  logic [31:0]     pc_from_dsp,
  input  logic [31:0]     rollback_pc_from_dsp,
  output logic [ID_W-1:0] rob_id_to_dsp,
  output logic            full_to_if,
  input  logic [ID_W-1:0] Q1_from_dsp,
  input  logic [ID_W-1:0] Q2_from_dsp,
  output logic            Q1_ready_to_dsp,
  output logic            Q2_ready_to_dsp,
  output logic [31:0]     ready_data1_to_dsp,
  output logic [31:0]     ready_data2_to_dsp,
  input  logic            valid_from_rs_cdb,
  input  logic [ID_W-1:0] rob_id_from_rs_cdb,
  input  logic [31:0]     result_from_rs_cdb,
  input  logic            valid_from_ls_cdb,
  input  logic [ID_W-1:0] rob_id_from_ls_cdb,
  input  logic [31:0]     result_from_ls_cdb,
  output logic            commit_ena_to_reg,
  output logic [4:0]      commit_rd_to_reg,
  output logic [31:0]     commit_data_to_reg,
  output logic [ID_W-1:0] commit_rob_id_to_reg,
  output logic            commit_ena_to_lsb,
  output logic [ID_W-1:0] commit_rob_id_to_lsb,
  output logic            rollback_flag_to_all,
  output logic [31:0]     rollback_pc_to_if
);

  localparam int CNT_W = $clog2(ROB_SIZE + 1);
  localparam logic [ID_W-1:0]  FIRST_ID = ID_W'(1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(ROB_SIZE);
  localparam logic [CNT_W-1:0] FULL_THR = CNT_W'(ROB_SIZE - 2);

  // Slot 0 exists only so that id 0 and out-of-range ids can index the
  // arrays; it is never allocated, so its busy bit stays 0.
  logic [ROB_SIZE:0] busy;
  logic [ROB_SIZE:0] ready;
  logic [ROB_SIZE:0] is_jump;
  logic [ROB_SIZE:0] pred_jump;
  logic [4:0]        rd_q    [0:ROB_SIZE];
  logic [31:0]       data_q  [0:ROB_SIZE];
  logic [31:0]       pc_q    [0:ROB_SIZE];
  logic [31:0]       rbpc_q  [0:ROB_SIZE];

  logic [ID_W-1:0]  head;
  logic [ID_W-1:0]  tail;
  logic [CNT_W-1:0] count;
  // Tracks the flush separately from the output pulse. The pulse drops when
  // rdy is low, but the flush must still happen on the next rdy cycle.
  logic             flush_pend;

  function automatic logic id_ok(input logic [ID_W-1:0] id);
    return (id != '0) && (id <= LAST_ID);
  endfunction

  function automatic logic [ID_W-1:0] idx_of(input logic [ID_W-1:0] id);
    return id_ok(id) ? id : '0;
  endfunction

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? FIRST_ID : id + FIRST_ID;
  endfunction

  logic [ID_W-1:0] q1_idx, q2_idx, rs_idx, ls_idx;
  logic            active, do_alloc, rs_wr, ls_wr;
  logic            head_commit, mispredict;
  logic [31:0]     commit_value;

  always_comb begin
    q1_idx = idx_of(Q1_from_dsp);
    q2_idx = idx_of(Q2_from_dsp);
    rs_idx = idx_of(rob_id_from_rs_cdb);
    ls_idx = idx_of(rob_id_from_ls_cdb);

    // Nothing is accepted in the cycle the flush is pending.
    active   = rdy && !flush_pend;
    do_alloc = active && ena_from_dsp;
    rs_wr    = active && valid_from_rs_cdb && busy[rs_idx];
    ls_wr    = active && valid_from_ls_cdb && busy[ls_idx];

    head_commit  = active && busy[head] && ready[head];
    // For jumps the RS result bit 0 is the actual taken outcome.
    mispredict   = is_jump[head] && (data_q[head][0] != pred_jump[head]);
    commit_value = is_jump[head] ? pc_q[head] + 32'd4 : data_q[head];
  end

  // Queries look at registered state only.
  assign Q1_ready_to_dsp    = busy[q1_idx] && ready[q1_idx];
  assign Q2_ready_to_dsp    = busy[q2_idx] && ready[q2_idx];
  assign ready_data1_to_dsp = Q1_ready_to_dsp ? data_q[q1_idx] : 32'd0;
  assign ready_data2_to_dsp = Q2_ready_to_dsp ? data_q[q2_idx] : 32'd0;

  assign rob_id_to_dsp = tail;
  assign full_to_if    = (count >= FULL_THR);

  // Entry payload, without reset; it is only read while the entry is busy.
  always_ff @(posedge clk) begin
    if (ls_wr) data_q[ls_idx] <= result_from_ls_cdb;
    if (rs_wr) data_q[rs_idx] <= result_from_rs_cdb;
    if (do_alloc) begin
      rd_q[tail]      <= rd_from_dsp;
      is_jump[tail]   <= is_jump_from_dsp;
      pred_jump[tail] <= predicted_jump_from_dsp;
      pc_q[tail]      <= pc_from_dsp;
      rbpc_q[tail]    <= rollback_pc_from_dsp;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy                 <= '0;
      ready                <= '0;
      head                 <= FIRST_ID;
      tail                 <= FIRST_ID;
      count                <= '0;
      flush_pend           <= 1'b0;
      commit_ena_to_reg    <= 1'b0;
      commit_rd_to_reg     <= '0;
      commit_data_to_reg   <= '0;
      commit_rob_id_to_reg <= '0;
      commit_ena_to_lsb    <= 1'b0;
      commit_rob_id_to_lsb <= '0;
      rollback_flag_to_all <= 1'b0;
      rollback_pc_to_if    <= '0;
    end else if (!rdy) begin
      commit_ena_to_reg    <= 1'b0;
      commit_ena_to_lsb    <= 1'b0;
      rollback_flag_to_all <= 1'b0;
    end else if (flush_pend) begin
      busy                 <= '0;
      head                 <= FIRST_ID;
      tail                 <= FIRST_ID;
      count                <= '0;
      flush_pend           <= 1'b0;
      commit_ena_to_reg    <= 1'b0;
      commit_ena_to_lsb    <= 1'b0;
      rollback_flag_to_all <= 1'b0;
    end else begin
      commit_ena_to_reg    <= 1'b0;
      commit_ena_to_lsb    <= 1'b0;
      rollback_flag_to_all <= 1'b0;

      // RS is written last, so it wins if both buses name the same id.
      if (ls_wr) ready[ls_idx] <= 1'b1;
      if (rs_wr) ready[rs_idx] <= 1'b1;

      if (head_commit) begin
        busy[head]           <= 1'b0;
        head                 <= next_id(head);
        commit_ena_to_reg    <= 1'b1;
        commit_rd_to_reg     <= rd_q[head];
        commit_data_to_reg   <= commit_value;
        commit_rob_id_to_reg <= head;
        commit_ena_to_lsb    <= 1'b1;
        commit_rob_id_to_lsb <= head;
        if (mispredict) begin
          rollback_flag_to_all <= 1'b1;
          rollback_pc_to_if    <= rbpc_q[head];
          flush_pend           <= 1'b1;
        end
      end

      // The allocation comes after the commit, so that a slot freed in this
      // cycle ends up busy again.
      if (do_alloc) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= next_id(tail);
      end

      case ({do_alloc, head_commit})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed self-checking bench for reorder_buffer.
// Drives a linear sequence of steps. Expected values are written by hand.
module tb_reorder_buffer;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        ena_from_dsp;
  logic [4:0]  rd_from_dsp;
  logic        is_jump_from_dsp;
  logic        predicted_jump_from_dsp;
  logic [31:0] pc_from_dsp;
  logic [31:0] rollback_pc_from_dsp;
  logic [4:0]  rob_id_to_dsp;
  logic        full_to_if;
  logic [4:0]  Q1_from_dsp;
  logic [4:0]  Q2_from_dsp;
  logic        Q1_ready_to_dsp;
  logic        Q2_ready_to_dsp;
  logic [31:0] ready_data1_to_dsp;
  logic [31:0] ready_data2_to_dsp;
  logic        valid_from_rs_cdb;
  logic [4:0]  rob_id_from_rs_cdb;
  logic [31:0] result_from_rs_cdb;
  logic        valid_from_ls_cdb;
  logic [4:0]  rob_id_from_ls_cdb;
  logic [31:0] result_from_ls_cdb;
  logic        commit_ena_to_reg;
  logic [4:0]  commit_rd_to_reg;
  logic [31:0] commit_data_to_reg;
  logic [4:0]  commit_rob_id_to_reg;
  logic        commit_ena_to_lsb;
  logic [4:0]  commit_rob_id_to_lsb;
  logic        rollback_flag_to_all;
  logic [31:0] rollback_pc_to_if;

  int checks = 0;
  int errors = 0;

  reorder_buffer #(.ROB_SIZE(16), .ID_W(5)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .rdy                     (rdy),
    .ena_from_dsp            (ena_from_dsp),
    .rd_from_dsp             (rd_from_dsp),
    .is_jump_from_dsp        (is_jump_from_dsp),
    .predicted_jump_from_dsp (predicted_jump_from_dsp),
    .pc_from_dsp             (pc_from_dsp),
    .rollback_pc_from_dsp    (rollback_pc_from_dsp),
    .rob_id_to_dsp           (rob_id_to_dsp),
    .full_to_if              (full_to_if),
    .Q1_from_dsp             (Q1_from_dsp),
    .Q2_from_dsp             (Q2_from_dsp),
    .Q1_ready_to_dsp         (Q1_ready_to_dsp),
    .Q2_ready_to_dsp         (Q2_ready_to_dsp),
    .ready_data1_to_dsp      (ready_data1_to_dsp),
    .ready_data2_to_dsp      (ready_data2_to_dsp),
    .valid_from_rs_cdb       (valid_from_rs_cdb),
    .rob_id_from_rs_cdb      (rob_id_from_rs_cdb),
    .result_from_rs_cdb      (result_from_rs_cdb),
    .valid_from_ls_cdb       (valid_from_ls_cdb),
    .rob_id_from_ls_cdb      (rob_id_from_ls_cdb),
    .result_from_ls_cdb      (result_from_ls_cdb),
    .commit_ena_to_reg       (commit_ena_to_reg),
    .commit_rd_to_reg        (commit_rd_to_reg),
    .commit_data_to_reg      (commit_data_to_reg),
    .commit_rob_id_to_reg    (commit_rob_id_to_reg),
    .commit_ena_to_lsb       (commit_ena_to_lsb),
    .commit_rob_id_to_lsb    (commit_rob_id_to_lsb),
    .rollback_flag_to_all    (rollback_flag_to_all),
    .rollback_pc_to_if       (rollback_pc_to_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge, and outputs are sampled then.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic j, input logic p,
                       input logic [31:0] pc, input logic [31:0] rbpc);
    ena_from_dsp            = 1'b1;
    rd_from_dsp             = rd;
    is_jump_from_dsp        = j;
    predicted_jump_from_dsp = p;
    pc_from_dsp             = pc;
    rollback_pc_from_dsp    = rbpc;
    tick();
    ena_from_dsp            = 1'b0;
  endtask

  task automatic cdb_rs(input logic [4:0] id, input logic [31:0] val);
    valid_from_rs_cdb  = 1'b1;
    rob_id_from_rs_cdb = id;
    result_from_rs_cdb = val;
    tick();
    valid_from_rs_cdb  = 1'b0;
  endtask

  task automatic cdb_ls(input logic [4:0] id, input logic [31:0] val);
    valid_from_ls_cdb  = 1'b1;
    rob_id_from_ls_cdb = id;
    result_from_ls_cdb = val;
    tick();
    valid_from_ls_cdb  = 1'b0;
  endtask

  task automatic query1(input string tag, input logic [4:0] q,
                        input logic er, input logic [31:0] ed);
    Q1_from_dsp = q;
    #1;
    chk1({tag, ".q1_ready"}, Q1_ready_to_dsp, er);
    chk32({tag, ".q1_data"}, ready_data1_to_dsp, ed);
  endtask

  task automatic query2(input string tag, input logic [4:0] q,
                        input logic er, input logic [31:0] ed);
    Q2_from_dsp = q;
    #1;
    chk1({tag, ".q2_ready"}, Q2_ready_to_dsp, er);
    chk32({tag, ".q2_data"}, ready_data2_to_dsp, ed);
  endtask

  task automatic expect_commit(input string tag, input logic en, input logic [4:0] rd,
                               input logic [31:0] d, input logic [4:0] id);
    chk1({tag, ".reg_ena"}, commit_ena_to_reg, en);
    chk1({tag, ".lsb_ena"}, commit_ena_to_lsb, en);
    if (en) begin
      chk5({tag, ".rd"}, commit_rd_to_reg, rd);
      chk32({tag, ".data"}, commit_data_to_reg, d);
      chk5({tag, ".reg_id"}, commit_rob_id_to_reg, id);
      chk5({tag, ".lsb_id"}, commit_rob_id_to_lsb, id);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    rdy = 1'b1;
    ena_from_dsp = 1'b0;
    rd_from_dsp = '0;
    is_jump_from_dsp = 1'b0;
    predicted_jump_from_dsp = 1'b0;
    pc_from_dsp = '0;
    rollback_pc_from_dsp = '0;
    Q1_from_dsp = '0;
    Q2_from_dsp = '0;
    valid_from_rs_cdb = 1'b0;
    rob_id_from_rs_cdb = '0;
    result_from_rs_cdb = '0;
    valid_from_ls_cdb = 1'b0;
    rob_id_from_ls_cdb = '0;
    result_from_ls_cdb = '0;

    // Power-on reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk5("por.rob_id", rob_id_to_dsp, 5'd1);
    chk1("por.full", full_to_if, 1'b0);
    chk1("por.reg_ena", commit_ena_to_reg, 1'b0);
    chk1("por.lsb_ena", commit_ena_to_lsb, 1'b0);
    chk1("por.flag", rollback_flag_to_all, 1'b0);
    chk32("por.rb_pc", rollback_pc_to_if, 32'd0);
    query1("por", 5'd0, 1'b0, 32'd0);
    tick();
    rst_n = 1'b1;

    // A single ALU instruction.
    alloc(5'd3, 1'b0, 1'b0, 32'h1000, 32'h0);
    chk5("alu.rob_id", rob_id_to_dsp, 5'd2);
    query1("alu.alloc", 5'd1, 1'b0, 32'd0);
    cdb_rs(5'd1, 32'h2A);
    query1("alu.wb", 5'd1, 1'b1, 32'h2A);
    expect_commit("alu.pre", 1'b0, 5'd0, 32'd0, 5'd0);
    tick();
    expect_commit("alu.commit", 1'b1, 5'd3, 32'h2A, 5'd1);
    tick();
    expect_commit("alu.post", 1'b0, 5'd0, 32'd0, 5'd0);
    query1("alu.retired", 5'd1, 1'b0, 32'd0);

    // Out-of-order completion, in-order retirement.
    do_reset();
    alloc(5'd1, 1'b0, 1'b0, 32'h10, 32'h0);
    alloc(5'd2, 1'b0, 1'b0, 32'h14, 32'h0);
    alloc(5'd3, 1'b0, 1'b0, 32'h18, 32'h0);
    chk5("ooo.rob_id", rob_id_to_dsp, 5'd4);
    cdb_rs(5'd3, 32'h33);
    cdb_ls(5'd2, 32'h22);
    cdb_rs(5'd1, 32'h11);
    expect_commit("ooo.none", 1'b0, 5'd0, 32'd0, 5'd0);
    tick();
    expect_commit("ooo.c1", 1'b1, 5'd1, 32'h11, 5'd1);
    tick();
    expect_commit("ooo.c2", 1'b1, 5'd2, 32'h22, 5'd2);
    tick();
    expect_commit("ooo.c3", 1'b1, 5'd3, 32'h33, 5'd3);
    tick();
    expect_commit("ooo.idle", 1'b0, 5'd0, 32'd0, 5'd0);

    // Fill the buffer, then wrap the tail past the last id.
    do_reset();
    for (int i = 0; i < 13; i++) alloc(5'(i + 1), 1'b0, 1'b0, 32'(i * 4), 32'h0);
    chk1("fill.13_full", full_to_if, 1'b0);
    alloc(5'd14, 1'b0, 1'b0, 32'h34, 32'h0);
    chk1("fill.14_full", full_to_if, 1'b1);
    chk5("fill.rob_id", rob_id_to_dsp, 5'd15);
    cdb_rs(5'd1, 32'h101);
    cdb_rs(5'd2, 32'h102);
    expect_commit("fill.c1", 1'b1, 5'd1, 32'h101, 5'd1);
    tick();
    expect_commit("fill.c2", 1'b1, 5'd2, 32'h102, 5'd2);
    chk1("fill.12_full", full_to_if, 1'b0);
    chk5("wrap.id15", rob_id_to_dsp, 5'd15);
    alloc(5'd15, 1'b0, 1'b0, 32'h38, 32'h0);
    chk5("wrap.id16", rob_id_to_dsp, 5'd16);
    alloc(5'd16, 1'b0, 1'b0, 32'h3C, 32'h0);
    chk5("wrap.id1", rob_id_to_dsp, 5'd1);
    alloc(5'd17, 1'b0, 1'b0, 32'h40, 32'h0);
    chk5("wrap.id2", rob_id_to_dsp, 5'd2);
    alloc(5'd18, 1'b0, 1'b0, 32'h44, 32'h0);
    chk5("wrap.id3", rob_id_to_dsp, 5'd3);
    chk1("wrap.full", full_to_if, 1'b1);
    query1("wrap.realloc1", 5'd1, 1'b0, 32'd0);

    // A mispredicted jump with two younger entries behind it.
    do_reset();
    alloc(5'd1, 1'b1, 1'b0, 32'h200, 32'h100);
    alloc(5'd5, 1'b0, 1'b0, 32'h204, 32'h0);
    alloc(5'd6, 1'b0, 1'b0, 32'h208, 32'h0);
    cdb_rs(5'd2, 32'h77);
    cdb_rs(5'd1, 32'h1);
    expect_commit("mis.pre", 1'b0, 5'd0, 32'd0, 5'd0);
    chk1("mis.pre_flag", rollback_flag_to_all, 1'b0);
    tick();
    expect_commit("mis.commit", 1'b1, 5'd1, 32'h204, 5'd1);
    chk1("mis.flag", rollback_flag_to_all, 1'b1);
    chk32("mis.rb_pc", rollback_pc_to_if, 32'h100);
    // An allocation and a CDB beat in the flag cycle must be dropped.
    ena_from_dsp = 1'b1;
    rd_from_dsp = 5'd7;
    is_jump_from_dsp = 1'b0;
    valid_from_rs_cdb = 1'b1;
    rob_id_from_rs_cdb = 5'd3;
    result_from_rs_cdb = 32'h99;
    tick();
    ena_from_dsp = 1'b0;
    valid_from_rs_cdb = 1'b0;
    chk1("mis.flag_drop", rollback_flag_to_all, 1'b0);
    expect_commit("mis.flush", 1'b0, 5'd0, 32'd0, 5'd0);
    chk5("mis.rob_id", rob_id_to_dsp, 5'd1);
    chk1("mis.full", full_to_if, 1'b0);
    query1("mis.young2", 5'd2, 1'b0, 32'd0);
    query2("mis.young3", 5'd3, 1'b0, 32'd0);
    tick();
    expect_commit("mis.after", 1'b0, 5'd0, 32'd0, 5'd0);
    chk32("mis.rb_pc_hold", rollback_pc_to_if, 32'h100);

    // A correctly predicted taken jump: no rollback.
    alloc(5'd2, 1'b1, 1'b1, 32'h300, 32'h500);
    cdb_rs(5'd1, 32'h1);
    tick();
    expect_commit("jok.commit", 1'b1, 5'd2, 32'h304, 5'd1);
    chk1("jok.flag", rollback_flag_to_all, 1'b0);

    // Both CDBs in the same cycle.
    do_reset();
    for (int i = 1; i <= 4; i++) alloc(5'(i), 1'b0, 1'b0, 32'(i * 4), 32'h0);
    valid_from_rs_cdb = 1'b1;
    rob_id_from_rs_cdb = 5'd2;
    result_from_rs_cdb = 32'hAAAA;
    valid_from_ls_cdb = 1'b1;
    rob_id_from_ls_cdb = 5'd4;
    result_from_ls_cdb = 32'hBBBB;
    tick();
    valid_from_rs_cdb = 1'b0;
    valid_from_ls_cdb = 1'b0;
    query1("dual.rs", 5'd2, 1'b1, 32'hAAAA);
    query2("dual.ls", 5'd4, 1'b1, 32'hBBBB);
    query1("dual.other", 5'd3, 1'b0, 32'd0);
    expect_commit("dual.none", 1'b0, 5'd0, 32'd0, 5'd0);
    cdb_ls(5'd7, 32'hDEAD);
    query1("dual.notbusy", 5'd7, 1'b0, 32'd0);

    // rdy low freezes state; registered pulses drop.
    alloc(5'd5, 1'b0, 1'b0, 32'h14, 32'h0);
    alloc(5'd6, 1'b0, 1'b0, 32'h18, 32'h0);
    cdb_rs(5'd1, 32'h1111);
    rdy = 1'b0;
    ena_from_dsp = 1'b1;
    tick();
    ena_from_dsp = 1'b0;
    expect_commit("rdy.freeze", 1'b0, 5'd0, 32'd0, 5'd0);
    chk5("rdy.rob_id", rob_id_to_dsp, 5'd7);
    query1("rdy.hold", 5'd1, 1'b1, 32'h1111);
    rdy = 1'b1;
    tick();
    expect_commit("rdy.resume", 1'b1, 5'd1, 32'h1111, 5'd1);

    // Asynchronous reset with five busy entries (ids 2..6).
    rst_n = 1'b0;
    #1;
    chk5("rst.rob_id", rob_id_to_dsp, 5'd1);
    chk1("rst.full", full_to_if, 1'b0);
    chk1("rst.reg_ena", commit_ena_to_reg, 1'b0);
    chk1("rst.lsb_ena", commit_ena_to_lsb, 1'b0);
    chk1("rst.flag", rollback_flag_to_all, 1'b0);
    chk5("rst.rd", commit_rd_to_reg, 5'd0);
    chk32("rst.data", commit_data_to_reg, 32'd0);
    chk32("rst.rb_pc", rollback_pc_to_if, 32'd0);
    query1("rst.busy2", 5'd2, 1'b0, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
